gsensor_spi_reader: RTL and testbench
=====================================

GSENSOR_SPI_READER -- requirements
Module: gsensor_spi_reader

Interface
REQ-001 Parameter CLK_DIV, default 25: system cycles per SCLK half-period (50 MHz / 50 = 1 MHz SCLK); legal range 2..255.
REQ-002 Parameter SAMPLE_PERIOD, default 500000: cycles between read-transaction starts (100 Hz); SHALL be >= 140*CLK_DIV.
REQ-003 MAX10_CLK1_50  in  1  system clock, all logic on rising edge.
REQ-004 RESET_N  in  1  asynchronous active-low reset.
REQ-005 GSENSOR_CS_N  out  1  SPI chip select, active low.
REQ-006 GSENSOR_SCLK  out  1  SPI clock, idle high (mode 3).
REQ-007 GSENSOR_SDI  out  1  SPI MOSI to the accelerometer.
REQ-008 GSENSOR_SDO  in  1  SPI MISO from the accelerometer.
REQ-009 ACC_X, ACC_Y, ACC_Z  out  16 each  last complete signed sample.
REQ-010 ACC_VALID  out  1  one-cycle pulse when ACC_X/Y/Z update.
REQ-011 INIT_DONE  out  1  high once the configuration writes have completed.

Function
REQ-012 SPI timing: half-period counter of CLK_DIV cycles; MOSI changes only on SCLK falling edges, MISO sampled on SCLK rising edges, MSB first.
REQ-013 CS_N falls one half-period before the first SCLK falling edge; rises one half-period after the last rising edge; minimum CS_N-high gap of 2 half-periods between transactions.
REQ-014 FSM states: BOOT, WR_FMT, GAP1, WR_PWR, WAIT, RD, LATCH.
REQ-015 BOOT: after reset release, wait 2 half-periods, then go to WR_FMT.
REQ-016 WR_FMT: 16-bit write of 0x31 then 0x0B (DATA_FORMAT: full-res, +/-16 g); then GAP1.
REQ-017 GAP1 -> WR_PWR: 16-bit write of 0x2D then 0x08 (POWER_CTL: measure); on completion INIT_DONE = 1 and enter WAIT with the sample timer cleared.
REQ-018 Sample timer counts 0..SAMPLE_PERIOD-1 free-running from INIT_DONE; each wrap to 0 starts a read when in WAIT.
REQ-019 RD: 56-bit transaction, command byte 0xF2 (read, multi-byte, address 0x32), then 48 MOSI-don't-care bits (driven 0) while 48 MISO bits are shifted in.
REQ-020 Byte order received: X0, X1, Y0, Y1, Z0, Z1; ACC_X = {X1,X0}, ACC_Y = {Y1,Y0}, ACC_Z = {Z1,Z0}.
REQ-021 LATCH: all three outputs update on the same cycle, ACC_VALID pulses on that cycle only, then return to WAIT; partial data is never visible on outputs.
REQ-022 A timer wrap occurring while not in WAIT is dropped (no queued read); the next wrap is used.
REQ-023 INIT_DONE, once set, stays high until reset.

Reset
REQ-024 On RESET_N low, immediately and asynchronously: CS_N = 1, SCLK = 1, SDI = 0, ACC_X/Y/Z = 0, ACC_VALID = 0, INIT_DONE = 0, FSM = BOOT, all counters 0.
REQ-025 Reset asserted mid-transaction aborts it with no output update; after release the full init sequence reruns.

Verification
REQ-026 CLK_DIV=4, SPI slave model: after reset release, capture MOSI bytes 0x31,0x0B then 0x2D,0x08 in two separate CS_N frames, each 16 SCLK rising edges; INIT_DONE rises after the second frame.
REQ-027 Slave returns 0x34,0x12,0xCD,0xAB,0x00,0x80 -> ACC_X=0x1234, ACC_Y=0xABCD, ACC_Z=0x8000, ACC_VALID high exactly one cycle.
REQ-028 SAMPLE_PERIOD=1000: consecutive CS_N falling edges of read frames exactly 1000 cycles apart; each frame 56 SCLK rising edges, first byte 0xF2.
REQ-029 Check SCLK half-period = 4 cycles, idle high, MOSI stable across every rising edge, CS_N setup/hold of one half-period.
REQ-030 Assert RESET_N low at bit 30 of a read -> CS_N and SCLK high same cycle, ACC_X/Y/Z=0, no ACC_VALID; after release init frames repeat.
REQ-031 Hold slave MISO at 1 for a full read -> ACC_X=ACC_Y=ACC_Z=0xFFFF after LATCH.

Source files
------------

// File: rtl/gsensor_spi_reader_if.sv
// SPI pins and sample outputs of the accelerometer reader, grouped for port passing.
// The reader uses the master modport; an accelerometer model uses the slave modport.
interface gsensor_spi_reader_if;
  logic        GSENSOR_CS_N;
  logic        GSENSOR_SCLK;
  logic        GSENSOR_SDI;
  logic        GSENSOR_SDO;
  logic [15:0] ACC_X;
  logic [15:0] ACC_Y;
  logic [15:0] ACC_Z;
  logic        ACC_VALID;
  logic        INIT_DONE;

  modport master (
    output GSENSOR_CS_N, GSENSOR_SCLK, GSENSOR_SDI,
    input  GSENSOR_SDO,
    output ACC_X, ACC_Y, ACC_Z, ACC_VALID, INIT_DONE
  );

  modport slave (
    input  GSENSOR_CS_N, GSENSOR_SCLK, GSENSOR_SDI,
    output GSENSOR_SDO,
    input  ACC_X, ACC_Y, ACC_Z, ACC_VALID, INIT_DONE
  );
endinterface

// File: rtl/gsensor_spi_reader.sv
// Mode-3 SPI master for an ADXL345-style accelerometer: two config writes, then
// periodic 6-byte burst reads latched atomically into ACC_X/Y/Z.
module gsensor_spi_reader #(
  parameter int unsigned CLK_DIV       = 25,
  parameter int unsigned SAMPLE_PERIOD = 500000
) (
  input  logic                  MAX10_CLK1_50,
  input  logic                  RESET_N,
  gsensor_spi_reader_if.master  bus
);

  localparam int unsigned SMP_W = $clog2(SAMPLE_PERIOD);

  typedef enum logic [2:0] {BOOT, WR_FMT, GAP1, WR_PWR, WAIT, RD, LATCH} state_t;

  state_t             state_q, state_d;
  logic [7:0]         hp_cnt;
  logic [6:0]         hidx;
  logic [6:0]         last_hidx;
  logic               hp_tick;
  logic               frame_st;
  logic               frame_end;
  logic [55:0]        tx_sh;
  logic [47:0]        rx_sh;
  logic               sclk_q;
  logic               sdi_q;
  logic [15:0]        acc_x_q, acc_y_q, acc_z_q;
  logic               init_q;
  logic [SMP_W-1:0]   smp_cnt;
  logic               smp_wrap;
  logic               cs_n;
  logic               acc_valid;

  assign hp_tick = (hp_cnt == 8'(CLK_DIV - 1));

  // hidx counts half-periods inside the current state: even ticks drop SCLK,
  // odd ticks raise it, and tick 2*N closes the frame one half-period later.
  always_comb begin
    frame_st  = state_q inside {WR_FMT, WR_PWR, RD};
    last_hidx = (state_q == RD) ? 7'd112 : 7'd32;
    frame_end = frame_st && hp_tick && (hidx == last_hidx);
    smp_wrap  = init_q && (smp_cnt == SMP_W'(SAMPLE_PERIOD - 1));
  end

  always_ff @(posedge MAX10_CLK1_50 or negedge RESET_N) begin
    if (!RESET_N) state_q <= BOOT;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    if (hp_tick && hidx == 7'd1) state_d = WR_FMT;
      WR_FMT:  if (frame_end)               state_d = GAP1;
      GAP1:    if (hp_tick && hidx == 7'd1) state_d = WR_PWR;
      WR_PWR:  if (frame_end)               state_d = WAIT;
      WAIT:    if (smp_wrap)                state_d = RD;
      RD:      if (frame_end)               state_d = LATCH;
      LATCH:                                state_d = WAIT;
      default:                              state_d = BOOT;
    endcase
  end

  always_comb begin
    cs_n      = !frame_st;
    acc_valid = (state_q == LATCH);
  end

  always_ff @(posedge MAX10_CLK1_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      hp_cnt <= '0;
      hidx   <= '0;
    end else if (state_d != state_q) begin
      hp_cnt <= '0;
      hidx   <= '0;
    end else if (state_q inside {BOOT, GAP1, WR_FMT, WR_PWR, RD}) begin
      if (hp_tick) begin
        hp_cnt <= '0;
        hidx   <= hidx + 7'd1;
      end else begin
        hp_cnt <= hp_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge MAX10_CLK1_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      tx_sh  <= '0;
      rx_sh  <= '0;
      sclk_q <= 1'b1;
      sdi_q  <= 1'b0;
    end else if (state_d != state_q && (state_d inside {WR_FMT, WR_PWR, RD})) begin
      case (state_d)
        WR_FMT:  tx_sh <= {16'h310B, 40'h0};
        WR_PWR:  tx_sh <= {16'h2D08, 40'h0};
        default: tx_sh <= {8'hF2, 48'h0};
      endcase
      sclk_q <= 1'b1;
      sdi_q  <= 1'b0;
    end else if (frame_st && hp_tick) begin
      if (hidx == last_hidx) begin
        sclk_q <= 1'b1;
        sdi_q  <= 1'b0;
      end else if (!hidx[0]) begin
        sclk_q <= 1'b0;
        sdi_q  <= tx_sh[55];
        tx_sh  <= {tx_sh[54:0], 1'b0};
      end else begin
        sclk_q <= 1'b1;
        rx_sh  <= {rx_sh[46:0], bus.GSENSOR_SDO};
      end
    end
  end

  // The command byte shifts out of rx_sh; the last 48 bits are X0 X1 Y0 Y1 Z0 Z1.
  always_ff @(posedge MAX10_CLK1_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      acc_x_q <= '0;
      acc_y_q <= '0;
      acc_z_q <= '0;
    end else if (state_q == RD && frame_end) begin
      acc_x_q <= {rx_sh[39:32], rx_sh[47:40]};
      acc_y_q <= {rx_sh[23:16], rx_sh[31:24]};
      acc_z_q <= {rx_sh[7:0],   rx_sh[15:8]};
    end
  end

  always_ff @(posedge MAX10_CLK1_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      init_q  <= 1'b0;
      smp_cnt <= '0;
    end else if (state_q == WR_PWR && frame_end) begin
      init_q  <= 1'b1;
      smp_cnt <= '0;
    end else if (init_q) begin
      smp_cnt <= smp_wrap ? '0 : smp_cnt + SMP_W'(1);
    end
  end

  assign bus.GSENSOR_CS_N = cs_n;
  assign bus.GSENSOR_SCLK = sclk_q;
  assign bus.GSENSOR_SDI  = sdi_q;
  assign bus.ACC_X        = acc_x_q;
  assign bus.ACC_Y        = acc_y_q;
  assign bus.ACC_Z        = acc_z_q;
  assign bus.ACC_VALID    = acc_valid;
  assign bus.INIT_DONE    = init_q;

endmodule

// File: tb/tb_gsensor_spi_reader.sv
// Directed bench for gsensor_spi_reader: SPI slave model, frame monitor and
// hand-computed expectations for init, reads, all-ones data and mid-read reset.
module tb_gsensor_spi_reader;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gsensor_spi_reader_if bus();

  gsensor_spi_reader #(.CLK_DIV(4), .SAMPLE_PERIOD(1000)) dut (
    .MAX10_CLK1_50 (clk),
    .RESET_N       (rst_n),
    .bus           (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Accelerometer model: drives MISO on SCLK falling edges.
  logic [55:0] resp    = {8'h00, 48'h3412CDAB0080};
  logic        sdo_drv = 1'b0;
  bit          all_ones = 1'b0;
  int          k = 0;
  assign bus.GSENSOR_SDO = sdo_drv;

  always @(negedge bus.GSENSOR_CS_N or negedge bus.GSENSOR_SCLK) begin
    if (bus.GSENSOR_SCLK) k = 0;
    else if (!bus.GSENSOR_CS_N) begin
      sdo_drv = all_ones ? 1'b1 : ((k < 56) ? resp[55-k] : 1'b0);
      k++;
    end
  end

  // Frame monitor, sampled on the falling system clock edge.
  int          cyc = 0, hp_err = 0, stab_err = 0, idle_err = 0, valid_cnt = 0;
  int          rise_cnt = 0, last_ev = 0, cur_start = 0;
  bit          in_frame = 1'b0;
  logic        p_cs = 1'b1, p_sclk = 1'b1, p_sdi = 1'b0;
  logic [63:0] mosi_sh = '0;
  int          fr_len[$];
  logic [63:0] fr_bits[$];
  int          fr_start[$];
  logic        fr_init[$];

  always @(negedge clk) begin
    cyc++;
    if (bus.ACC_VALID) valid_cnt++;
    if (bus.GSENSOR_CS_N && !bus.GSENSOR_SCLK) idle_err++;
    if (!rst_n) begin
      in_frame = 1'b0;
    end else begin
      if (p_cs && !bus.GSENSOR_CS_N) begin
        in_frame  = 1'b1;
        last_ev   = cyc;
        cur_start = cyc;
        rise_cnt  = 0;
        mosi_sh   = '0;
      end else if (in_frame && (bus.GSENSOR_SCLK != p_sclk || bus.GSENSOR_CS_N)) begin
        if (cyc - last_ev != 4) hp_err++;
        last_ev = cyc;
      end
      if (in_frame && bus.GSENSOR_SCLK && !p_sclk) begin
        rise_cnt++;
        mosi_sh = {mosi_sh[62:0], bus.GSENSOR_SDI};
        if (bus.GSENSOR_SDI != p_sdi) stab_err++;
      end
      if (in_frame && bus.GSENSOR_CS_N) begin
        fr_len.push_back(rise_cnt);
        fr_bits.push_back(mosi_sh);
        fr_start.push_back(cur_start);
        fr_init.push_back(bus.INIT_DONE);
        in_frame = 1'b0;
      end
    end
    p_cs   = bus.GSENSOR_CS_N;
    p_sclk = bus.GSENSOR_SCLK;
    p_sdi  = bus.GSENSOR_SDI;
  end

  function automatic int len_of(input int i);
    return (i < fr_len.size()) ? fr_len[i] : -1;
  endfunction

  function automatic logic [15:0] word_of(input int i);
    if (i >= fr_bits.size()) return 16'hDEAD;
    return (fr_len[i] == 16) ? fr_bits[i][15:0] : {8'h00, fr_bits[i][55:48]};
  endfunction

  function automatic logic [47:0] tail_of(input int i);
    return (i < fr_bits.size()) ? fr_bits[i][47:0] : 48'hDEAD;
  endfunction

  function automatic int start_of(input int i);
    return (i < fr_start.size()) ? fr_start[i] : -1;
  endfunction

  function automatic logic init_of(input int i);
    return (i < fr_init.size()) ? fr_init[i] : 1'bx;
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_init(input string tag);
    for (int i = 0; i < 2000; i++) begin
      if (bus.INIT_DONE) return;
      tick();
    end
    check(tag, 64'd0, 64'd1);
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 3000; i++) begin
      if (bus.ACC_VALID) return;
      tick();
    end
    check(tag, 64'd0, 64'd1);
  endtask

  task automatic wait_bit30(input string tag);
    for (int i = 0; i < 3000; i++) begin
      if (in_frame && rise_cnt >= 30) return;
      tick();
    end
    check(tag, 64'd0, 64'd1);
  endtask

  initial begin
    int base;
    repeat (3) tick();
    check("rst_cs_n",  bus.GSENSOR_CS_N, 1'b1);
    check("rst_sclk",  bus.GSENSOR_SCLK, 1'b1);
    check("rst_sdi",   bus.GSENSOR_SDI, 1'b0);
    check("rst_acc",   {bus.ACC_X, bus.ACC_Y, bus.ACC_Z}, 48'h0);
    check("rst_valid", bus.ACC_VALID, 1'b0);
    check("rst_init",  bus.INIT_DONE, 1'b0);

    rst_n = 1'b1;
    wait_init("init_timeout");
    check("init_frames", fr_len.size(), 2);
    check("fmt_len",     len_of(0), 16);
    check("fmt_word",    word_of(0), 16'h310B);
    check("fmt_init_lo", init_of(0), 1'b0);
    check("pwr_len",     len_of(1), 16);
    check("pwr_word",    word_of(1), 16'h2D08);
    check("pwr_init_hi", init_of(1), 1'b1);
    check("init_acc0",   {bus.ACC_X, bus.ACC_Y, bus.ACC_Z}, 48'h0);

    wait_valid("rd1_timeout");
    check("rd1_x",    bus.ACC_X, 16'h1234);
    check("rd1_y",    bus.ACC_Y, 16'hABCD);
    check("rd1_z",    bus.ACC_Z, 16'h8000);
    check("rd1_len",  len_of(2), 56);
    check("rd1_cmd",  word_of(2), 16'h00F2);
    check("rd1_tail", tail_of(2), 48'h0);
    tick();
    check("rd1_pulse", bus.ACC_VALID, 1'b0);
    check("rd1_hold",  bus.ACC_X, 16'h1234);

    wait_valid("rd2_timeout");
    check("rd2_len",    len_of(3), 56);
    check("rd2_cmd",    word_of(3), 16'h00F2);
    check("rd2_period", start_of(3) - start_of(2), 1000);
    check("rd2_y",      bus.ACC_Y, 16'hABCD);
    tick();
    check("rd2_pulse", bus.ACC_VALID, 1'b0);

    all_ones = 1'b1;
    wait_valid("ones_timeout");
    check("ones_acc", {bus.ACC_X, bus.ACC_Y, bus.ACC_Z}, 48'hFFFF_FFFF_FFFF);
    check("ones_period", start_of(4) - start_of(3), 1000);
    tick();

    wait_bit30("bit30_timeout");
    rst_n = 1'b0;
    #1;
    check("abort_cs_n", bus.GSENSOR_CS_N, 1'b1);
    check("abort_sclk", bus.GSENSOR_SCLK, 1'b1);
    check("abort_acc",  {bus.ACC_X, bus.ACC_Y, bus.ACC_Z}, 48'h0);
    check("abort_valid", bus.ACC_VALID, 1'b0);
    check("abort_init", bus.INIT_DONE, 1'b0);
    base = fr_len.size();
    repeat (3) tick();
    all_ones = 1'b0;
    rst_n = 1'b1;
    wait_init("reinit_timeout");
    check("reinit_frames", fr_len.size() - base, 2);
    check("reinit_fmt",    word_of(base), 16'h310B);
    check("reinit_pwr",    word_of(base + 1), 16'h2D08);
    check("reinit_len",    len_of(base + 1), 16);
    check("reinit_acc0",   {bus.ACC_X, bus.ACC_Y, bus.ACC_Z}, 48'h0);

    check("half_period", hp_err, 0);
    check("mosi_stable", stab_err, 0);
    check("sclk_idle",   idle_err, 0);
    check("valid_count", valid_cnt, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
